// File: rtl/commit_trace_pkg.sv
// Shared types and widths for the commit trace queue.
//   PC_W         : width of pc / nextpc / instruction fields
//   CNT_W        : width of the retired-instruction counter
//   commit_rec_t : one retired-instruction record {pc, nextpc, inst}
package commit_trace_pkg;

   localparam int PC_W  = 32;
   localparam int CNT_W = 64;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] nextpc;
      logic [PC_W-1:0] inst;
   } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit records with wrap-bit pointers.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   push_i, push_data_i : write request and record (ignored when full)
//   pop_i               : read request (ignored when empty)
//   full_o, empty_o     : occupancy flags, from registered pointers only
//   head_o              : record at the read pointer (undefined when empty)
module commit_fifo
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  commit_rec_t push_data_i,
   input  logic        pop_i,
   output logic        full_o,
   output logic        empty_o,
   output commit_rec_t head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   commit_rec_t mem_q [DEPTH];
   logic        do_push, do_pop;

   // The extra MSB distinguishes a full queue from an empty one.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; empty-gating downstream hides stale slots.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/commit_trace_queue.sv
// Elastic buffer between commit and the commit reporter, with pc-flow
// continuity check, retired-instruction counter and commit watchdog.
//   clock, reset                      : clock, asynchronous active-high reset
//   in_valid/in_ready, in_pc/nextpc/inst : record input handshake
//   out_valid/out_ready, out_pc/nextpc/inst : head record, zero when empty
//   commit_cnt : records popped since reset (wraps)
//   flow_err   : sticky, a popped pc differed from the previous nextpc
//   hang       : sticky, WD_LIMIT cycles elapsed without an accepted push
module commit_trace_queue
   import commit_trace_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int WD_LIMIT = 4096
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [PC_W-1:0]  in_nextpc,
   input  logic [PC_W-1:0]  in_inst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [PC_W-1:0]  out_nextpc,
   output logic [PC_W-1:0]  out_inst,
   output logic [CNT_W-1:0] commit_cnt,
   output logic             flow_err,
   output logic             hang
);

   localparam int WD_W = $clog2(WD_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

   commit_rec_t      in_rec, head_rec, out_rec;
   logic             full, empty, push, pop;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  last_nextpc_q, last_nextpc_d;
   logic             seen_q, seen_d;
   logic             flow_err_q, flow_err_d;
   logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
   logic             hang_q, hang_d;

   assign in_rec = '{pc: in_pc, nextpc: in_nextpc, inst: in_inst};

   commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clock),
      .rst_i       (reset),
      .push_i      (push),
      .push_data_i (in_rec),
      .pop_i       (pop),
      .full_o      (full),
      .empty_o     (empty),
      .head_o      (head_rec)
   );

   // Ready depends on registered pointers only, so a full queue refuses a
   // push even in a cycle that also pops.
   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_rec    = empty ? '0 : head_rec;
   assign out_pc     = out_rec.pc;
   assign out_nextpc = out_rec.nextpc;
   assign out_inst   = out_rec.inst;

   assign commit_cnt = cnt_q;
   assign flow_err   = flow_err_q;
   assign hang       = hang_q;

   always_comb begin
      cnt_d         = cnt_q;
      last_nextpc_d = last_nextpc_q;
      seen_d        = seen_q;
      flow_err_d    = flow_err_q;
      if (pop) begin
         cnt_d         = cnt_q + 1'b1;
         last_nextpc_d = out_nextpc;
         seen_d        = 1'b1;
         // The very first pop has no predecessor to compare against.
         if (seen_q && (out_pc != last_nextpc_q)) flow_err_d = 1'b1;
      end

      if (push)                  wd_cnt_d = '0;
      else if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
      else                       wd_cnt_d = wd_cnt_q;
      hang_d = hang_q | (wd_cnt_d == WD_MAX);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         last_nextpc_q <= '0;
         seen_q        <= 1'b0;
         flow_err_q    <= 1'b0;
         wd_cnt_q      <= '0;
         hang_q        <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         last_nextpc_q <= last_nextpc_d;
         seen_q        <= seen_d;
         flow_err_q    <= flow_err_d;
         wd_cnt_q      <= wd_cnt_d;
         hang_q        <= hang_d;
      end
   end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Scoreboard bench for commit_trace_queue (DEPTH=4, WD_LIMIT=8).
module tb_commit_trace_queue;
   import commit_trace_pkg::*;

   localparam int DEPTH = 4;
   localparam int WD    = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0, in_nextpc = '0, in_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc, out_nextpc, out_inst;
   logic [63:0] commit_cnt;
   logic        flow_err, hang;

   commit_trace_queue #(.DEPTH(DEPTH), .WD_LIMIT(WD)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pc      (in_pc),
      .in_nextpc  (in_nextpc),
      .in_inst    (in_inst),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pc     (out_pc),
      .out_nextpc (out_nextpc),
      .out_inst   (out_inst),
      .commit_cnt (commit_cnt),
      .flow_err   (flow_err),
      .hang       (hang)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   commit_rec_t exp_q[$];
   logic [63:0] m_cnt = '0;
   logic [31:0] m_last = '0;
   bit          m_seen = 0;
   bit          m_flow = 0;
   int          m_wd = 0;
   bit          m_hang = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit push, pop;
      commit_rec_t r;
      if (reset) begin
         exp_q.delete();
         m_cnt = '0; m_last = '0; m_seen = 0; m_flow = 0; m_wd = 0; m_hang = 0;
      end else begin
         push = in_valid && (exp_q.size() < DEPTH);
         pop  = out_ready && (exp_q.size() > 0);
         if (pop) begin
            r = exp_q.pop_front();
            if (m_seen && r.pc != m_last) m_flow = 1;
            m_last = r.nextpc;
            m_seen = 1;
            m_cnt  = m_cnt + 64'd1;
         end
         if (push) exp_q.push_back('{pc: in_pc, nextpc: in_nextpc, inst: in_inst});
         if (push) m_wd = 0;
         else if (m_wd < WD) m_wd++;
         if (m_wd == WD) m_hang = 1;
      end
   endtask

   initial forever begin
      @(posedge clock or posedge reset);
      model_step();
   end

   // Monitor: compare DUT outputs against the model away from the clock edge.
   initial forever begin
      @(negedge clock);
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
         chk("out_nextpc", 64'(out_nextpc), 64'(exp_q[0].nextpc));
         chk("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
      end else begin
         chk("out_zero", {out_pc, out_nextpc | out_inst}, 64'd0);
      end
      chk("commit_cnt", commit_cnt, m_cnt);
      chk("flow_err", 64'(flow_err), 64'(m_flow));
      chk("hang", 64'(hang), 64'(m_hang));
   end

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Hold a record on the input until accepted, bounded.
   task automatic offer(input logic [31:0] pc, input logic [31:0] npc, input logic [31:0] inst);
      bit acc;
      acc = 0;
      in_valid = 1'b1; in_pc = pc; in_nextpc = npc; in_inst = inst;
      for (int k = 0; k < 50 && !acc; k++) begin
         acc = in_ready;
         cycle();
      end
      in_valid = 1'b0;
      n_checks++;
      if (!acc) begin
         n_errors++;
         $display("FAIL offer_timeout: got not-accepted expected accepted pc=%0h", pc);
      end
   endtask

   initial begin
      logic [31:0] pc, npc;
      bit acc;

      do_reset();
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);

      // Single record with consumer ready
      out_ready = 1'b1;
      offer(32'h8000_0000, 32'h8000_0004, 32'h0000_0013);
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_pc", 64'(out_pc), 64'h8000_0000);
      repeat (2) cycle();
      chk("t1_cnt", commit_cnt, 64'd1);
      chk("t1_flow", 64'(flow_err), 64'd0);

      // Fill with consumer stalled, then push against a full queue while popping
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         offer(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 32'(i));
      chk("t2_full_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      offer(32'h110, 32'h114, 32'd4);
      repeat (8) cycle();
      chk("t2_cnt", commit_cnt, 64'd5);
      chk("t2_flow", 64'(flow_err), 64'd0);

      // Flow discontinuity
      do_reset();
      out_ready = 1'b1;
      offer(32'h8000_0000, 32'h8000_0004, 32'h1);
      offer(32'h8000_0010, 32'h8000_0014, 32'h2);
      repeat (3) cycle();
      chk("t3_flow_set", 64'(flow_err), 64'd1);
      offer(32'h8000_0014, 32'h8000_0018, 32'h3);
      repeat (2) cycle();
      chk("t3_flow_sticky", 64'(flow_err), 64'd1);

      // Watchdog
      do_reset();
      repeat (7) cycle();
      chk("t4_hang_7", 64'(hang), 64'd0);
      cycle();
      chk("t4_hang_8", 64'(hang), 64'd1);
      offer(32'h200, 32'h204, 32'h5);
      cycle();
      chk("t4_hang_sticky", 64'(hang), 64'd1);
      do_reset();
      chk("t4_hang_reset", 64'(hang), 64'd0);

      // Randomized traffic with continuous pc flow
      pc = 32'h8000_0000;
      npc = 32'h8000_0004;
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         in_pc = pc; in_nextpc = npc; in_inst = $urandom;
         acc = in_valid && in_ready;
         cycle();
         if (acc) begin
            pc = npc;
            npc = ($urandom_range(0, 7) == 0) ? pc + 32'(4 * $urandom_range(0, 64)) - 32'd128 : pc + 32'd4;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) cycle();
      chk("rnd_flow", 64'(flow_err), 64'd0);

      // Asynchronous reset while holding records
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         offer(pc + 32'(4 * i), pc + 32'(4 * i + 4), 32'(i));
      chk("t5_pre_valid", 64'(out_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_cnt", commit_cnt, 64'd0);
      chk("t5_flags", {62'd0, flow_err, hang}, 64'd0);
      chk("t5_out_pc", 64'(out_pc), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (3) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
